scanline_fetch: RTL
===================

Name: scanline_fetch

Overview:
- Read-side display stage that sits between the SDRAM Avalon-MM port (through the burst arbiter) and the VGA pixel output.
- While line N is displayed, it prefetches framebuffer line N+1 from SDRAM into a ping-pong line buffer.
- It expands RGB565 to 8-bit RGB, with one pixel out per pixel_en.
- Underruns are flagged and never stall the raster.

Parameters:
- FB_BASE, 25'h0, word address of framebuffer line 0
- H_ACTIVE, 640, visible pixels per line
- V_ACTIVE, 480, visible lines
- V_TOTAL, 525, total lines per frame, including blanking
- WORDS_PER_LINE, 320, 32-bit words per line (2 pixels per word)
- MAX_OUTSTANDING, 8, maximum read requests in flight
- UNDERRUN_RGB, 24'hFF00FF, colour output on underrun

Ports:
- Clk  in  1  system clock, 50 MHz
- Reset_n  in  1  synchronous, active-low reset
- pixel_en  in  1  one-cycle strobe per VGA pixel period
- DrawX  in  10  current raster X
- DrawY  in  10  current raster Y
- bus_req  out  1  request for the SDRAM port
- bus_gnt  in  1  grant from the arbiter
- address_out  out  25  Avalon word address
- read_n  out  1  Avalon read, active low
- wait_req  in  1  Avalon waitrequest
- valid  in  1  Avalon readdatavalid
- data_from_mem  in  32  Avalon readdata
- red  out  8  pixel red
- green  out  8  pixel green
- blue  out  8  pixel blue
- underrun  out  1  sticky underrun flag, cleared at frame start
- busy  out  1  a line fetch is in progress

Behaviour:
- Reset (Reset_n=0 at a Clk edge):
  - Outputs: red/green/blue=0, read_n=1, bus_req=0, address_out=0, underrun=0, busy=0.
  - Internal state: FSM=IDLE, outstanding=0, issued=0, received=0, fill counts=0, write bank=0.
  - Any readdatavalid arriving after reset while outstanding==0 is discarded.
- Fetch trigger (one-cycle pulse, inside the block):
  - Fires on pixel_en with DrawX==H_ACTIVE (first hblank pixel).
  - Target line is DrawY+1 when DrawY<V_ACTIVE-1, and 0 when DrawY==V_TOTAL-1.
  - No trigger fires on any other line.
- FSM states: IDLE, REQ, ISSUE, DRAIN.
  - IDLE: on trigger, latch the target line, set issued=received=0, go to REQ. busy=1 in every state except IDLE.
  - REQ: assert bus_req. Go to ISSUE when bus_gnt=1.
  - ISSUE:
    - read_n=0 while issued<WORDS_PER_LINE and outstanding<MAX_OUTSTANDING.
    - address_out = FB_BASE + line*320 + issued, with line*320 computed as (line<<8)+(line<<6).
    - issued increments only on a cycle where read_n=0 and wait_req=0.
    - When issued==WORDS_PER_LINE, go to DRAIN.
    - bus_gnt dropping mid-burst: read_n=1, return to REQ; issued is kept.
  - DRAIN: drop bus_req. When received==WORDS_PER_LINE and outstanding==0, flip write bank and go to IDLE.
- Outstanding counter:
  - +1 per accepted read, -1 per valid.
  - Both in the same cycle: no change.
  - Never exceeds MAX_OUTSTANDING.
- Receive path:
  - Each valid writes data_from_mem into write_bank[received], then received+1.
  - The fill count for that bank mirrors received.
- Trigger while FSM not IDLE: ignored; underrun is set.
- Display path:
  - Reads bank !write_bank at word DrawX>>1.
  - Pixel = word[15:0] if DrawX[0]=0, else word[31:16].
  - Expansion: R8={r5,r5[4:2]}, G8={g6,g6[5:4]}, B8={b5,b5[4:2]}.
  - Outputs are registered and update on pixel_en; latency is 1 pixel_en after DrawX is presented.
  - When DrawX>=H_ACTIVE or DrawY>=V_ACTIVE, output 0.
  - When the word index is >= the display bank's fill count, output UNDERRUN_RGB and set underrun.
- underrun clears on pixel_en with DrawX==0, DrawY==0.
- Arithmetic: all counters are 9 bits and never wrap beyond WORDS_PER_LINE. address_out is truncated to 25 bits.

Optional Feature:
- Macro: SCANLINE_FETCH_STATS_EN.
- Defined:
  - Adds output underrun_count[15:0]: counts underrun pixels per frame, saturating at 16'hFFFF.
  - Adds output last_frame_underruns[15:0]: latched at frame start, then the counter zeroes.
  - Both reset to 0.
- Undefined: neither port exists; no counter logic.

Decomposition:
- Package scanline_pkg holds:
  - the FSM state enum (IDLE/REQ/ISSUE/DRAIN)
  - the rgb565_t packed struct {r[4:0], g[5:0], b[4:0]}
  - an expand565 function
  - the H_ACTIVE/V_ACTIVE/V_TOTAL defaults
- One sub-module: line_buffer_2x.
  - Dual-bank 2x320x32 simple dual-port RAM.
  - Write port: bank, addr, data, we. Read port: bank, addr; 1-cycle registered read.
  - Infers M9K.

Test Plan:
- Reset check: hold Reset_n=0 for 3 cycles mid-ISSUE, with valid pulses afterwards -> read_n=1, bus_req=0, outstanding=0, stale valids ignored, no buffer write.
- Basic fetch: DrawY=9 trigger, memory returns word=address, wait_req=0, gnt=1 -> 320 reads at FB_BASE+3200..3519; bank flips after the last valid; busy low.
- Backpressure: wait_req random 50%, latency 5 cycles -> outstanding never exceeds 8; each address issued exactly once; 320 words received in order.
- Grant loss: bus_gnt dropped after 100 accepted reads for 20 cycles -> read_n=1 during the gap; resumes at offset 100; no duplicate or skipped address.
- Pixel output: word 32'h07E0F800 at index 0 -> DrawX=0 gives FF,00,00 and DrawX=1 gives 00,FF,00, one pixel_en later.
- Underrun: responses stalled so fill=10 when DrawX=40 -> UNDERRUN_RGB FF00FF output, underrun=1; cleared at the next (0,0); with SCANLINE_FETCH_STATS_EN, underrun_count is correct.

Source files
------------

// File: rtl/scanline_pkg.sv
// scanline_pkg: shared types, raster defaults and colour helper
// for the scanline fetch stage (see scanline_fetch.sv).
package scanline_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_TOTAL_DEF  = 525;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    ISSUE,
    DRAIN
  } fetch_state_t;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  function automatic logic [23:0] expand565(rgb565_t p);
    return {p.r, p.r[4:2], p.g, p.g[5:4], p.b, p.b[4:2]};
  endfunction

endpackage

// File: rtl/line_buffer_2x.sv
// line_buffer_2x: ping-pong line store, two banks of DEPTH words,
// one write port and one registered read port (block-RAM friendly).
module line_buffer_2x #(
  parameter int DEPTH = 320,
  parameter int AW    = 9
) (
  input  logic          clk,
  input  logic          wr_bank,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_data,
  input  logic          we,
  input  logic          rd_bank,
  input  logic [AW-1:0] rd_addr,
  output logic [31:0]   rd_data
);

  logic [31:0] mem [2][DEPTH];

  // write port
  always_ff @(posedge clk) begin
    if (we) mem[wr_bank][wr_addr] <= wr_data;
  end

  // registered read port
  always_ff @(posedge clk) begin
    rd_data <= mem[rd_bank][rd_addr];
  end

endmodule

// File: rtl/scanline_fetch.sv
// scanline_fetch: prefetches framebuffer line N+1 into a ping-pong
// buffer while line N is shown. Macro SCANLINE_FETCH_STATS_EN adds stats.
module scanline_fetch
  import scanline_pkg::*;
#(
  parameter logic [24:0] FB_BASE         = 25'h0,
  parameter int          H_ACTIVE        = H_ACTIVE_DEF,
  parameter int          V_ACTIVE        = V_ACTIVE_DEF,
  parameter int          V_TOTAL         = V_TOTAL_DEF,
  parameter int          WORDS_PER_LINE  = 320,
  parameter int          MAX_OUTSTANDING = 8,
  parameter logic [23:0] UNDERRUN_RGB    = 24'hFF00FF
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        pixel_en,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic [24:0] address_out,
  output logic        read_n,
  input  logic        wait_req,
  input  logic        valid,
  input  logic [31:0] data_from_mem,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic        underrun,
  output logic        busy
`ifdef SCANLINE_FETCH_STATS_EN
  ,
  output logic [15:0] underrun_count,
  output logic [15:0] last_frame_underruns
`endif
);

  localparam logic [8:0] WPL  = 9'(WORDS_PER_LINE);
  localparam logic [3:0] MAXO = 4'(MAX_OUTSTANDING);

  fetch_state_t state, state_nx;

  logic [9:0]  line;
  logic [8:0]  issued;
  logic [8:0]  received;
  logic [3:0]  outstanding;
  logic [8:0]  fill [2];
  logic        wbank;
  logic        trig;
  logic        trig_go;
  logic [9:0]  target;
  logic        acc;
  logic        vld;
  logic        done;
  logic [24:0] line_off;

  assign trig = pixel_en
    && DrawX == 10'(H_ACTIVE)
    && (DrawY < 10'(V_ACTIVE - 1)
        || DrawY == 10'(V_TOTAL - 1));
  assign target = (DrawY == 10'(V_TOTAL - 1))
    ? 10'd0 : DrawY + 10'd1;
  assign trig_go = trig && state == IDLE;
  assign acc = !read_n && !wait_req;
  // responses with nothing in flight are stale
  assign vld = valid && outstanding != 4'd0
    && received < WPL;
  assign done = received == WPL && outstanding == 4'd0;
  assign line_off = ({15'd0, line} << 8)
    + ({15'd0, line} << 6);

  // state register
  always_ff @(posedge Clk) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // next state and bus outputs
  always_comb begin
    state_nx    = state;
    bus_req     = 1'b0;
    read_n      = 1'b1;
    busy        = 1'b1;
    address_out = '0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (trig) state_nx = REQ;
      end
      REQ: begin
        bus_req = 1'b1;
        if (bus_gnt) state_nx = ISSUE;
      end
      ISSUE: begin
        bus_req     = 1'b1;
        address_out = FB_BASE + line_off
          + {16'd0, issued};
        if (issued == WPL)            state_nx = DRAIN;
        else if (!bus_gnt)            state_nx = REQ;
        else if (outstanding < MAXO)  read_n = 1'b0;
      end
      DRAIN: begin
        if (done) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // fetch counters, fill levels and bank select
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      line        <= '0;
      issued      <= '0;
      received    <= '0;
      outstanding <= '0;
      fill[0]     <= '0;
      fill[1]     <= '0;
      wbank       <= 1'b0;
    end else begin
      if (trig_go) begin
        line        <= target;
        issued      <= '0;
        received    <= '0;
        fill[wbank] <= '0;
      end else begin
        if (acc) issued <= issued + 9'd1;
        if (vld) begin
          received    <= received + 9'd1;
          fill[wbank] <= received + 9'd1;
        end
      end
      outstanding <= outstanding + {3'd0, acc}
        - {3'd0, vld};
      if (state == DRAIN && done) wbank <= ~wbank;
    end
  end

  logic [31:0] rd_word;
  logic [8:0]  rd_idx;
  logic        rbank;
  logic        blank;
  logic        ur_pix;
  logic        frame_start;
  rgb565_t     pix;

  assign rbank  = ~wbank;
  assign rd_idx = DrawX[9:1];

  line_buffer_2x #(
    .DEPTH (WORDS_PER_LINE),
    .AW    (9)
  ) u_buf (
    .clk     (Clk),
    .wr_bank (wbank),
    .wr_addr (received),
    .wr_data (data_from_mem),
    .we      (vld),
    .rd_bank (rbank),
    .rd_addr (rd_idx),
    .rd_data (rd_word)
  );

  assign blank = DrawX >= 10'(H_ACTIVE)
    || DrawY >= 10'(V_ACTIVE);
  assign ur_pix = !blank && rd_idx >= fill[rbank];
  assign pix = DrawX[0] ? rd_word[31:16]
    : rd_word[15:0];
  assign frame_start = pixel_en
    && DrawX == 10'd0 && DrawY == 10'd0;

  // pixel output register
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      {red, green, blue} <= '0;
    end else if (pixel_en) begin
      if (blank)       {red, green, blue} <= '0;
      else if (ur_pix) {red, green, blue} <= UNDERRUN_RGB;
      else             {red, green, blue} <= expand565(pix);
    end
  end

  // sticky underrun; a new event at frame start wins over clear
  always_ff @(posedge Clk) begin
    if (!Reset_n)
      underrun <= 1'b0;
    else if ((pixel_en && ur_pix) || (trig && state != IDLE))
      underrun <= 1'b1;
    else if (frame_start)
      underrun <= 1'b0;
  end

`ifdef SCANLINE_FETCH_STATS_EN
  // per-frame underrun pixel count, saturating
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      underrun_count       <= '0;
      last_frame_underruns <= '0;
    end else if (frame_start) begin
      last_frame_underruns <= underrun_count;
      underrun_count       <= ur_pix ? 16'd1 : 16'd0;
    end else if (pixel_en && ur_pix
                 && underrun_count != 16'hFFFF) begin
      underrun_count <= underrun_count + 16'd1;
    end
  end
`endif

endmodule
